// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the shared register-file write port, plus the per-register pending scoreboard.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build is fixed priority (lowest index wins).
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_rd,
  output logic [2**AW-1:0]     busy,
  output logic                 regwrite,
  output logic [AW-1:0]        rd,
  output logic [XLEN-1:0]      rd_data
);

  localparam int NREG = 2**AW;
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic            xfer;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx;

  // Search starts one past the last winner and wraps, so the last winner has lowest priority.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= IW'(NREQ - 1);
    end else if (xfer) begin
      rr_ptr <= grant_idx;
    end
  end
`else
  // Scanning downward lets the lowest valid index overwrite any higher one.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end
`endif

  // Grants are suppressed while reset is held, so no transfer can be offered during reset.
  assign xfer = grant_any & ~rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  assign win_rd   = req_rd[int'(grant_idx)*AW +: AW];
  assign win_data = req_data[int'(grant_idx)*XLEN +: XLEN];

`ifdef WB_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
`else
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
`endif
    if (rst) begin
      regwrite <= 1'b0;
      rd       <= '0;
      rd_data  <= '0;
    end else if (xfer) begin
      regwrite <= (win_rd != '0);
      rd       <= win_rd;
      rd_data  <= win_data;
    end else begin
      regwrite <= 1'b0;
    end
  end

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_next;
  logic [NREG-1:0] wr_mask;
  logic [NREG-1:0] alloc_mask;

  always_comb begin
    wr_mask    = '0;
    alloc_mask = '0;
    if (regwrite) wr_mask[rd] = 1'b1;
    if (alloc_valid && (alloc_rd != '0)) alloc_mask[alloc_rd] = 1'b1;
    // Set is applied after clear so a new producer of the register being written stays pending.
    sb_next    = ((sb & ~wr_mask) | alloc_mask) & ~NREG'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb <= '0;
    else     sb <= sb_next;
  end

  // The register file forwards rd_data in the write cycle, so that register is not reported busy.
  assign busy = sb & ~wr_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps then random traffic against a queue-based model.
// The arbitration model follows WB_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 2**AW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 alloc_valid;
  logic [AW-1:0]        alloc_rd;
  logic [NREG-1:0]      busy;
  logic                 regwrite;
  logic [AW-1:0]        rd;
  logic [XLEN-1:0]      rd_data;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .busy(busy), .regwrite(regwrite), .rd(rd), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } item_t;

  // Reference model: pending results per requester, last winner, write stage and pending set.
  item_t           q[NREQ][$];
  int              m_ptr;
  bit              m_wr;
  int              m_rd;
  logic [XLEN-1:0] m_data;
  bit              m_sb[NREG];
  logic            alloc_v;
  logic [AW-1:0]   alloc_r;
  logic [NREQ-1:0] obs_ready;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
`ifdef WB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (q[i].size() != 0) return i;
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (q[i].size() != 0) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [NREG-1:0] exp_busy();
    logic [NREG-1:0] v = '0;
    for (int r = 1; r < NREG; r++) begin
      if (m_sb[r] && !(m_wr && m_rd == r)) v[r] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_ptr  = NREQ - 1;
    m_wr   = 1'b0;
    m_rd   = 0;
    m_data = '0;
    for (int r = 0; r < NREG; r++) m_sb[r] = 1'b0;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    alloc_v = 1'b0;
    alloc_r = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (q[i].size() != 0);
      req_rd[i*AW +: AW]       = (q[i].size() != 0) ? q[i][0].rd   : '0;
      req_data[i*XLEN +: XLEN] = (q[i].size() != 0) ? q[i][0].data : '0;
    end
    alloc_valid = alloc_v;
    alloc_rd    = alloc_r;
  endtask

  // Called at posedge+1: drive, check at posedge+2, advance the model across the edge, return at posedge+1.
  task automatic cycle(input string tag);
    int w;
    logic [NREQ-1:0] exp_ready;
    drive();
    #1;
    w = pick();
    exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
    obs_ready = req_ready;
    check({tag, ".ready"},    req_ready, exp_ready);
    check({tag, ".regwrite"}, regwrite,  m_wr);
    check({tag, ".rd"},       rd,        m_rd);
    check({tag, ".rd_data"},  rd_data,   m_data);
    check({tag, ".busy"},     busy,      exp_busy());
    @(posedge clk);
    if (m_wr) m_sb[m_rd] = 1'b0;
    if (alloc_v && alloc_r != '0) m_sb[alloc_r] = 1'b1;
    if (w >= 0) begin
      m_rd   = int'(q[w][0].rd);
      m_data = q[w][0].data;
      m_wr   = (m_rd != 0);
      m_ptr  = w;
      void'(q[w].pop_front());
    end else begin
      m_wr = 1'b0;
    end
    alloc_v = 1'b0;
    #1;
  endtask

  // Asserts reset without first touching the request inputs, so held requests must be masked by reset.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".regwrite"}, regwrite,  1'b0);
    check({tag, ".rd"},       rd,        '0);
    check({tag, ".rd_data"},  rd_data,   '0);
    check({tag, ".busy"},     busy,      '0);
    check({tag, ".ready"},    req_ready, '0);
    model_reset();
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int budget = 20;
    while ((q[0].size() + q[1].size() + q[2].size() != 0 || m_wr) && budget > 0) begin
      cycle(tag);
      budget--;
    end
    check({tag, ".drained"}, budget > 0, 1'b1);
  endtask

  initial begin
    logic [NREG-1:0] busy_before;
    req_valid   = '0;
    req_rd      = '0;
    req_data    = '0;
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    model_reset();
    apply_reset("rst0");

    // Single write from req0, one-cycle latency, then idle.
    q[0].push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    cycle("t1a");
    check("t1.grant", obs_ready, 3'b001);
    check("t1.we",    regwrite,  1'b1);
    check("t1.rd",    rd,        5'd5);
    check("t1.data",  rd_data,   32'hDEADBEEF);
    cycle("t1b");
    check("t1.idle",  regwrite,  1'b0);

    // All three requesters valid from reset.
    apply_reset("rst1");
    for (int k = 0; k < 3; k++) q[0].push_back('{rd: AW'(10 + k), data: $urandom});
    q[1].push_back('{rd: 5'd20, data: $urandom});
    q[2].push_back('{rd: 5'd21, data: $urandom});
    cycle("t2a");
    check("t2.g0", obs_ready, 3'b001);
    cycle("t2b");
`ifdef WB_ARB_ROUND_ROBIN_EN
    check("t2.g1", obs_ready, 3'b010);
`else
    check("t2.g1", obs_ready, 3'b001);
`endif
    cycle("t2c");
`ifdef WB_ARB_ROUND_ROBIN_EN
    check("t2.g2", obs_ready, 3'b100);
`else
    check("t2.g2", obs_ready, 3'b001);
`endif
    drain("t2d");

    // Allocate x7, later written back by req1.
    alloc_v = 1'b1; alloc_r = 5'd7;
    cycle("t3a");
    check("t3.busy_set", busy[7], 1'b1);
    repeat (3) cycle("t3b");
    q[1].push_back('{rd: 5'd7, data: 32'h0000_0777});
    cycle("t3c");
    check("t3.we",         regwrite, 1'b1);
    check("t3.busy_fwd",   busy[7],  1'b0);
    cycle("t3d");
    check("t3.busy_clear", busy[7],  1'b0);

    // Allocation and write of x9 in the same cycle: set wins.
    q[0].push_back('{rd: 5'd9, data: 32'h0000_0999});
    cycle("t4a");
    check("t4.we", regwrite, 1'b1);
    alloc_v = 1'b1; alloc_r = 5'd9;
    cycle("t4b");
    check("t4.set_wins", busy[9], 1'b1);

    // Writes and allocations of x0 are absorbed.
    q[2].push_back('{rd: 5'd0, data: 32'h0000_1234});
    cycle("t5a");
    check("t5.grant", obs_ready, 3'b100);
    check("t5.no_we", regwrite,  1'b0);
    check("t5.busy0", busy[0],   1'b0);
    busy_before = busy;
    alloc_v = 1'b1; alloc_r = 5'd0;
    cycle("t5b");
    check("t5.alloc0", busy, busy_before);

    // Asynchronous reset in the middle of a write cycle.
    apply_reset("rst2");
    alloc_v = 1'b1; alloc_r = 5'd7;
    cycle("t6a");
    q[0].push_back('{rd: 5'd3, data: 32'h0000_0333});
    cycle("t6b");
    q[1].push_back('{rd: 5'd4, data: 32'h0000_0444});
    drive();
    #1;
    check("t6.pre_ready", req_ready, 3'b010);
    check("t6.pre_we",    regwrite,  1'b1);
    check("t6.pre_busy",  busy,      32'h0000_0080);
    #1;
    apply_reset("t6.async");
    for (int i = 0; i < NREQ; i++) q[i].push_back('{rd: AW'(i + 1), data: $urandom});
    cycle("t6c");
    check("t6.g0", obs_ready, 3'b001);
    cycle("t6d");
    check("t6.g1", obs_ready, 3'b010);
    cycle("t6e");
    check("t6.g2", obs_ready, 3'b100);
    drain("t6f");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (q[i].size() < 2 && $urandom_range(0, 2) == 0) begin
          item_t it;
          it.rd   = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          it.data = $urandom;
          q[i].push_back(it);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        alloc_v = 1'b1;
        alloc_r = AW'($urandom);
      end
      cycle("rnd");
    end
    drain("rnd_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
